// File: rtl/jtkunio_bank_arb_pkg.sv
// jtkunio_bank_arb_pkg: FSM encoding, slot indices, bank address width and slot rotation helper
package jtkunio_bank_arb_pkg;
  localparam int BA_AW = 22;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;
  localparam logic [1:0] SLOT_MAIN = 2'd0;
  localparam logic [1:0] SLOT_SND  = 2'd1;
  localparam logic [1:0] SLOT_PCM  = 2'd2;
  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return s == SLOT_PCM ? SLOT_MAIN : s + 2'd1;
  endfunction
endpackage

// File: rtl/jtkunio_bank_arb_if.sv
// jtkunio_bank_arb_if: SDRAM bank read port (ba_addr/ba_rd out of arbiter; ba_ack/ba_rdy/data_read back)
interface jtkunio_bank_arb_if;
  import jtkunio_bank_arb_pkg::*;
  logic [BA_AW-1:0] ba_addr;
  logic             ba_rd;
  logic             ba_ack;
  logic             ba_rdy;
  logic [15:0]      data_read;
  modport master(output ba_addr, ba_rd, input ba_ack, ba_rdy, data_read);
  modport slave(input ba_addr, ba_rd, output ba_ack, ba_rdy, data_read);
endinterface

// File: rtl/jtkunio_bank_slot.sv
// jtkunio_bank_slot: one-word cache for a byte requester (cs/addr in; data/ok/miss out; fill port from arbiter)
module jtkunio_bank_slot #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [7:0]    data,
  output logic          ok,
  output logic          miss,
  input  logic          fill,
  input  logic          fill_valid,
  input  logic [AW-2:0] fill_tag,
  input  logic [15:0]   fill_data
);
  logic          valid;
  logic [AW-2:0] tag;
  logic [15:0]   word;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      word  <= '0;
    end else begin
      valid <= ~downloading & (fill ? fill_valid : valid);
      if (fill) begin
        tag  <= fill_tag;
        word <= fill_data;
      end
    end
  assign ok   = cs & valid & (tag == addr[AW-1:1]);
  assign miss = cs & ~ok;
  assign data = addr[0] ? word[15:8] : word[7:0];
endmodule

// File: rtl/jtkunio_bank_arb.sv
// jtkunio_bank_arb: round-robin arbiter of main/snd/pcm cached ROM slots onto one SDRAM bank read port (bank: master modport)
module jtkunio_bank_arb
  import jtkunio_bank_arb_pkg::*;
#(
  parameter int               AW0  = 16,
  parameter int               AW1  = 15,
  parameter int               AW2  = 17,
  parameter logic [BA_AW-1:0] OFF1 = 22'h0_8000,
  parameter logic [BA_AW-1:0] OFF2 = 22'h0_C000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic                  main_cs,
  input  logic [AW0-1:0]        main_addr,
  output logic [7:0]            main_data,
  output logic                  main_ok,
  input  logic                  snd_cs,
  input  logic [AW1-1:0]        snd_addr,
  output logic [7:0]            snd_data,
  output logic                  snd_ok,
  input  logic                  pcm_cs,
  input  logic [AW2-1:0]        pcm_addr,
  output logic [7:0]            pcm_data,
  output logic                  pcm_ok,
  jtkunio_bank_arb_if.master    bank
);
  localparam int TW = (AW0 > AW1 ? (AW0 > AW2 ? AW0 : AW2) : (AW1 > AW2 ? AW1 : AW2)) - 1;
  state_t           st, st_nx;
  logic [1:0]       gnt, gnt_nx, ptr, ptr_nx, s1, s2, pick;
  logic [TW-1:0]    ltag, ltag_nx, tag_sel;
  logic [BA_AW-1:0] addr_r, addr_nx, off_sel;
  logic             rd_r, rd_nx, disc, disc_nx, fill;
  logic [2:0]       miss;
  always_comb begin
    s1      = next_slot(ptr);
    s2      = next_slot(s1);
    pick    = miss[ptr] ? ptr : miss[s1] ? s1 : s2;
    tag_sel = pick == SLOT_MAIN ? TW'(main_addr[AW0-1:1]) :
              pick == SLOT_SND  ? TW'(snd_addr[AW1-1:1])  : TW'(pcm_addr[AW2-1:1]);
    off_sel = pick == SLOT_MAIN ? '0 : pick == SLOT_SND ? OFF1 : OFF2;
    // ack and rdy together in REQ count as ack followed by completion
    fill    = bank.ba_rdy & ((st == REQ & bank.ba_ack) | st == WAIT);
    st_nx   = st;
    gnt_nx  = gnt;
    ptr_nx  = ptr;
    ltag_nx = ltag;
    addr_nx = addr_r;
    rd_nx   = rd_r;
    // a download seen at any point of a transaction poisons its fill
    disc_nx = ~fill & st != IDLE & (disc | downloading);
    if (st == IDLE && !downloading && |miss) begin
      gnt_nx  = pick;
      ltag_nx = tag_sel;
      addr_nx = off_sel + BA_AW'(tag_sel);
      rd_nx   = 1'b1;
      st_nx   = REQ;
    end
    if (st == REQ && bank.ba_ack) begin
      rd_nx = 1'b0;
      st_nx = WAIT;
    end
    if (fill) begin
      ptr_nx = next_slot(gnt);
      st_nx  = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st     <= IDLE;
      gnt    <= SLOT_MAIN;
      ptr    <= SLOT_MAIN;
      ltag   <= '0;
      addr_r <= '0;
      rd_r   <= 1'b0;
      disc   <= 1'b0;
    end else begin
      st     <= st_nx;
      gnt    <= gnt_nx;
      ptr    <= ptr_nx;
      ltag   <= ltag_nx;
      addr_r <= addr_nx;
      rd_r   <= rd_nx;
      disc   <= disc_nx;
    end
  assign bank.ba_addr = addr_r;
  assign bank.ba_rd   = rd_r;
  jtkunio_bank_slot #(.AW(AW0)) u_main (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(main_cs), .addr(main_addr),
    .data(main_data), .ok(main_ok), .miss(miss[SLOT_MAIN]), .fill(fill & gnt == SLOT_MAIN),
    .fill_valid(~disc), .fill_tag(ltag[AW0-2:0]), .fill_data(bank.data_read)
  );
  jtkunio_bank_slot #(.AW(AW1)) u_snd (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(snd_cs), .addr(snd_addr),
    .data(snd_data), .ok(snd_ok), .miss(miss[SLOT_SND]), .fill(fill & gnt == SLOT_SND),
    .fill_valid(~disc), .fill_tag(ltag[AW1-2:0]), .fill_data(bank.data_read)
  );
  jtkunio_bank_slot #(.AW(AW2)) u_pcm (
    .clk(clk), .rst(rst), .downloading(downloading), .cs(pcm_cs), .addr(pcm_addr),
    .data(pcm_data), .ok(pcm_ok), .miss(miss[SLOT_PCM]), .fill(fill & gnt == SLOT_PCM),
    .fill_valid(~disc), .fill_tag(ltag[AW2-2:0]), .fill_data(bank.data_read)
  );
endmodule

// File: tb/tb_jtkunio_bank_arb.sv
// tb_jtkunio_bank_arb: directed and randomized check of the bank arbiter against a behavioural model
module tb_jtkunio_bank_arb;
  import jtkunio_bank_arb_pkg::*;
  logic clk = 0, rst = 0, downloading = 0;
  logic main_cs = 0, snd_cs = 0, pcm_cs = 0;
  logic [15:0] main_addr = 0;
  logic [14:0] snd_addr = 0;
  logic [16:0] pcm_addr = 0;
  logic [7:0] main_data, snd_data, pcm_data;
  logic main_ok, snd_ok, pcm_ok;
  int vecs = 0, errs = 0;
  jtkunio_bank_arb_if bank();
  jtkunio_bank_arb dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .main_cs(main_cs), .main_addr(main_addr), .main_data(main_data), .main_ok(main_ok),
    .snd_cs(snd_cs), .snd_addr(snd_addr), .snd_data(snd_data), .snd_ok(snd_ok),
    .pcm_cs(pcm_cs), .pcm_addr(pcm_addr), .pcm_data(pcm_data), .pcm_ok(pcm_ok),
    .bank(bank)
  );
  always #5 clk = ~clk;

  // behavioural model: caches, a transaction phase (0 none, 1 requesting, 2 awaiting data)
  bit          mv[3];
  int          mtag[3];
  logic [15:0] mword[3];
  int          ph, mgnt, mptr, mlt;
  logic [21:0] maddr;
  bit          mdisc;

  function automatic int a_of(int i);
    return i == 0 ? int'(main_addr) : i == 1 ? int'(snd_addr) : int'(pcm_addr);
  endfunction
  function automatic bit c_of(int i);
    return i == 0 ? main_cs : i == 1 ? snd_cs : pcm_cs;
  endfunction
  function automatic int o_of(int i);
    return i == 0 ? 0 : i == 1 ? 'h8000 : 'hC000;
  endfunction
  function automatic bit exp_ok(int i);
    return c_of(i) && mv[i] && mtag[i] == (a_of(i) >> 1);
  endfunction
  function automatic logic [7:0] exp_data(int i);
    return a_of(i) % 2 == 1 ? mword[i][15:8] : mword[i][7:0];
  endfunction
  function automatic logic ok_of(int i);
    return i == 0 ? main_ok : i == 1 ? snd_ok : pcm_ok;
  endfunction
  function automatic logic [7:0] data_of(int i);
    return i == 0 ? main_data : i == 1 ? snd_data : pcm_data;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 3; i++) begin mv[i] = 0; mtag[i] = 0; mword[i] = 0; end
      ph = 0; mgnt = 0; mptr = 0; mlt = 0; maddr = 0; mdisc = 0;
    end else begin
      bit f;
      f = (ph == 1 && bank.ba_ack && bank.ba_rdy) || (ph == 2 && bank.ba_rdy);
      if (f) begin
        mv[mgnt] = !(mdisc || downloading);
        mtag[mgnt] = mlt;
        mword[mgnt] = bank.data_read;
        mptr = (mgnt + 1) % 3;
        ph = 0;
        mdisc = 0;
      end else if (ph == 1 && bank.ba_ack) ph = 2;
      else if (ph == 0 && !downloading) begin
        for (int k = 0; k < 3; k++) begin
          int j;
          j = (mptr + k) % 3;
          if (ph == 0 && c_of(j) && !(mv[j] && mtag[j] == (a_of(j) >> 1))) begin
            ph = 1;
            mgnt = j;
            mlt = a_of(j) >> 1;
            maddr = 22'(o_of(j) + mlt);
          end
        end
      end
      if (!f && ph != 0 && downloading) mdisc = 1;
      if (downloading) for (int i = 0; i < 3; i++) mv[i] = 0;
    end

  always @(negedge clk)
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model ok[%0d]", i), 32'(ok_of(i)), 32'(exp_ok(i)));
        if (exp_ok(i)) chk($sformatf("model data[%0d]", i), 32'(data_of(i)), 32'(exp_data(i)));
      end
      chk("model ba_rd", 32'(bank.ba_rd), 32'(ph == 1));
      if (ph != 0) chk("model ba_addr", 32'(bank.ba_addr), 32'(maddr));
    end

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1;
    main_cs = 0; snd_cs = 0; pcm_cs = 0; downloading = 0;
    main_addr = 0; snd_addr = 0; pcm_addr = 0;
    bank.ba_ack = 0; bank.ba_rdy = 0; bank.data_read = 0;
    nxt;
    chk("rst main_ok", 32'(main_ok), 0);
    chk("rst snd_ok", 32'(snd_ok), 0);
    chk("rst pcm_ok", 32'(pcm_ok), 0);
    chk("rst data", {8'h0, main_data, snd_data, pcm_data}, 0);
    chk("rst ba_rd", 32'(bank.ba_rd), 0);
    chk("rst ba_addr", 32'(bank.ba_addr), 0);
    rst = 0;
  endtask

  task automatic wait_rd(input logic [21:0] ea);
    int n = 0;
    while (!bank.ba_rd && n < 20) begin nxt; n++; end
    chk("ba_rd seen", 32'(bank.ba_rd), 1);
    chk("ba_addr", 32'(bank.ba_addr), 32'(ea));
  endtask

  task automatic serve(input logic [21:0] ea, input logic [15:0] d, input bit both);
    wait_rd(ea);
    bank.ba_ack = 1;
    if (both) begin bank.ba_rdy = 1; bank.data_read = d; end
    nxt;
    bank.ba_ack = 0; bank.ba_rdy = 0;
    if (!both) begin
      bank.ba_rdy = 1; bank.data_read = d;
      nxt;
      bank.ba_rdy = 0;
    end
  endtask

  bit awaiting;
  int dly;
  initial begin
    #1;
    do_reset;
    // first miss, one-cycle request latency, fill then hit on the other byte
    main_cs = 1; main_addr = 16'h0001;
    #2 chk("miss main_ok", 32'(main_ok), 0);
    nxt;
    chk("lat ba_rd", 32'(bank.ba_rd), 1);
    chk("lat ba_addr", 32'(bank.ba_addr), 0);
    bank.ba_ack = 1;
    nxt;
    bank.ba_ack = 0;
    chk("ack drops ba_rd", 32'(bank.ba_rd), 0);
    bank.ba_rdy = 1; bank.data_read = 16'hA55A;
    nxt;
    bank.ba_rdy = 0;
    chk("fill main_ok", 32'(main_ok), 1);
    chk("fill main_data", 32'(main_data), 32'h A5);
    main_addr = 16'h0000;
    #2 chk("hit main_data", 32'(main_data), 32'h5A);
    chk("hit main_ok", 32'(main_ok), 1);
    nxt;
    chk("hit no ba_rd", 32'(bank.ba_rd), 0);
    // round robin, pcm served with ack and rdy together
    do_reset;
    main_cs = 1; snd_cs = 1; pcm_cs = 1; pcm_addr = 17'h2;
    serve(22'h0, 16'h1111, 0);
    serve(22'h8000, 16'h2222, 0);
    serve(22'hC001, 16'h3C4D, 1);
    chk("rr main_ok", 32'(main_ok), 1);
    chk("rr snd_data", 32'(snd_data), 32'h22);
    chk("rr pcm_ok", 32'(pcm_ok), 1);
    chk("rr pcm_data", 32'(pcm_data), 32'h4D);
    // address change while awaiting data
    do_reset;
    snd_cs = 1;
    wait_rd(22'h8000);
    bank.ba_ack = 1;
    nxt;
    bank.ba_ack = 0; snd_addr = 15'h4;
    nxt;
    bank.ba_rdy = 1; bank.data_read = 16'hBEEF;
    nxt;
    bank.ba_rdy = 0;
    #2 chk("moved snd_ok", 32'(snd_ok), 0);
    serve(22'h8002, 16'h1234, 0);
    chk("moved fill snd_ok", 32'(snd_ok), 1);
    chk("moved fill snd_data", 32'(snd_data), 32'h34);
    // download during an in-flight fill
    do_reset;
    main_cs = 1;
    wait_rd(22'h0);
    bank.ba_ack = 1;
    nxt;
    bank.ba_ack = 0; downloading = 1;
    nxt;
    downloading = 0; bank.ba_rdy = 1; bank.data_read = 16'h7788;
    nxt;
    bank.ba_rdy = 0; downloading = 1;
    #2 chk("dl main_ok", 32'(main_ok), 0);
    nxt;
    chk("dl blocks ba_rd 1", 32'(bank.ba_rd), 0);
    nxt;
    chk("dl blocks ba_rd 2", 32'(bank.ba_rd), 0);
    downloading = 0;
    serve(22'h0, 16'h99AA, 0);
    chk("dl refill main_ok", 32'(main_ok), 1);
    chk("dl refill main_data", 32'(main_data), 32'hAA);
    // randomized traffic with a responding bank
    do_reset;
    awaiting = 0; dly = 0;
    for (int c = 0; c < 3000; c++) begin
      nxt;
      if ($urandom_range(0, 3) == 0) main_addr = 16'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) snd_addr = 15'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) pcm_addr = 17'($urandom_range(0, 7));
      main_cs = $urandom_range(0, 3) != 0;
      snd_cs = $urandom_range(0, 3) != 0;
      pcm_cs = $urandom_range(0, 3) != 0;
      downloading = $urandom_range(0, 39) == 0;
      bank.ba_ack = 0; bank.ba_rdy = 0;
      if (awaiting) begin
        if (dly == 0) begin
          bank.ba_rdy = 1; bank.data_read = 16'($urandom); awaiting = 0;
        end else dly--;
      end else if (bank.ba_rd) begin
        if ($urandom_range(0, 1) == 1) begin
          bank.ba_ack = 1;
          dly = $urandom_range(0, 3);
          if (dly == 0 && $urandom_range(0, 1) == 1) begin
            bank.ba_rdy = 1; bank.data_read = 16'($urandom);
          end else awaiting = 1;
        end
      end else begin
        bank.ba_ack = $urandom_range(0, 7) == 0;
        bank.ba_rdy = $urandom_range(0, 7) == 0;
        bank.data_read = 16'($urandom);
      end
    end
    nxt;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
